// File: rtl/main_mem_responder.sv
// Word-addressed main-memory responder: single-cycle writes, reads returned
// through a fixed-latency pipeline with a one-cycle valid pulse.
`timescale 1ns/1ps
module main_mem_responder #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_BITS = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic [3:0]  pending
);

  localparam int WORDS = 1 << DEPTH_BITS;

  logic [15:0]           memArray_r [WORDS];
  logic [LATENCY-1:0]    stageValid_r;
  logic [15:0]           stageData_r [LATENCY];
  logic [DEPTH_BITS-1:0] wordIdx_s;
  logic                  readIssue_s;
  logic                  writeIssue_s;
  logic                  returning_s;
  logic [3:0]            pendingNext_s;
  logic                  unusedAddrBits_s;

  // Byte address to word index; bits above the storage depth alias.
  assign wordIdx_s        = addr[DEPTH_BITS:1];
  assign unusedAddrBits_s = ^addr;
  assign readIssue_s      = enable & ~wr;
  assign writeIssue_s     = enable & wr;
  assign returning_s      = stageValid_r[LATENCY-1];

  // Storage array: not touched by reset, contents survive it.
  always_ff @(posedge clk) begin
    if (writeIssue_s) begin
      memArray_r[wordIdx_s] <= data_in;
    end
  end

  // Read pipeline: snapshot taken at issue, shifts every edge without stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stageValid_r <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        stageData_r[i] <= 16'h0000;
      end
    end else begin
      stageValid_r[0] <= readIssue_s;
      stageData_r[0]  <= readIssue_s ? memArray_r[wordIdx_s] : 16'h0000;
      for (int i = 1; i < LATENCY; i++) begin
        stageValid_r[i] <= stageValid_r[i-1];
        stageData_r[i]  <= stageData_r[i-1];
      end
    end
  end

  // Outstanding-read count: issue and return on the same edge cancel.
  always_comb begin
    pendingNext_s = pending;
    if (readIssue_s && !returning_s) begin
      pendingNext_s = pending + 4'd1;
    end else if (!readIssue_s && returning_s) begin
      pendingNext_s = pending - 4'd1;
    end else begin
      pendingNext_s = pending;
    end
  end

  // Registered response and pending outputs; bubbles carry zero data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out   <= 16'h0000;
      data_valid <= 1'b0;
      pending    <= 4'd0;
    end else begin
      data_out   <= stageData_r[LATENCY-1];
      data_valid <= returning_s;
      pending    <= pendingNext_s;
    end
  end

endmodule
